// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register-file write-back path.
//   NUM_REGS / ADDR_W / DATA_W : register-file geometry
//   REG_SP / REG_RA            : architectural aliases for R14 / R15
//   SP_RESET                   : initial stack pointer value used by the core
//   req_id_e                   : identifies the two write-back producers
package regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam int REG_SP = 14;
    localparam int REG_RA = 15;

    localparam logic [31:0] SP_RESET = 32'h0000_1000;

    // Requester 0 is the ALU result path, requester 1 the load-return path.
    typedef enum logic [0:0] {
        REQ_EX  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// rr_arbiter2
// Two-input round-robin arbiter with a freeze input.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   hold       : when high no grant is issued and the pointer is frozen
//   req[1:0]   : request vector
//   grant[1:0] : one-hot (or zero) combinational grant
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Pointer names the requester that wins the next contested cycle.
    logic rr_ptr_r;
    logic freeze_s;
    logic [1:0] grant_s;

    // Grants are suppressed during reset as well as during hold.
    assign freeze_s = hold | Reset;

    // Grant selection: single requester wins outright, contention uses the pointer.
    always_comb begin
        grant_s = 2'b00;
        if (freeze_s) begin
            grant_s = 2'b00;
        end else begin
            case (req)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = (rr_ptr_r == REQ_MEM) ? 2'b10 : 2'b01;
                default: grant_s = 2'b00;
            endcase
        end
    end

    // Pointer moves to the loser only after a contested grant.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr_r <= 1'b0;
        end else if (!freeze_s && (req == 2'b11)) begin
            rr_ptr_r <= ~rr_ptr_r;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Arbitrates the EX and MEM write-back producers onto the single register
// file write port, registers the port, and keeps a per-register pending
// scoreboard that decode consults to stall operand reads.
// Ports:
//   Clk, Reset              : clock, synchronous active-high reset
//   wb_hold                 : freeze grants and write-port activity
//   req_valid / req_ready   : per-requester handshake (bit0 = EX, bit1 = MEM)
//   req_addr0/1, req_data0/1: destination register and data per requester
//   rsv_valid, rsv_addr     : decode reserves a destination register
//   rd_addr1, rd_addr2      : operands decode is about to read
//   rd_stall                : an operand is not yet valid in the register file
//   RegWrite/Write_Reg/Write_Data : registered register-file write port
//   pending                 : scoreboard, one bit per register
//   addr_err                : one-cycle pulse after an out-of-range address
module regfile_wb_scheduler
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W
)
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                wb_hold,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [ADDR_W-1:0]   req_addr0,
    input  logic [ADDR_W-1:0]   req_addr1,
    input  logic [DATA_W-1:0]   req_data0,
    input  logic [DATA_W-1:0]   req_data1,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic                rd_stall,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   Write_Reg,
    output logic [DATA_W-1:0]   Write_Data,
    output logic [NUM_REGS-1:0] pending,
    output logic                addr_err
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a < ADDR_LIMIT);
    endfunction

    // Scoreboard lookup; an out-of-range address matches no entry.
    function automatic logic pend_lookup(input logic [NUM_REGS-1:0] p,
                                         input logic [ADDR_W-1:0]   a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) begin
                hit = hit | p[i];
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    logic [1:0]          grant_s;
    req_id_e             sel_id_s;
    logic                handshake_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                sel_legal_s;
    logic                rsv_legal_s;
    logic                wr_accept_s;
    logic [NUM_REGS-1:0] pending_next_s;
    logic                rd_stall_s;

    logic                reg_write_r;
    logic [ADDR_W-1:0]   write_reg_r;
    logic [DATA_W-1:0]   write_data_r;
    logic [NUM_REGS-1:0] pending_r;
    logic                addr_err_r;

    rr_arbiter2 u_arb (
        .Clk   (Clk),
        .Reset (Reset),
        .hold  (wb_hold),
        .req   (req_valid),
        .grant (grant_s)
    );

    assign req_ready = grant_s;

    // Steer the granted requester's address and data onto the write path.
    always_comb begin
        handshake_s = |(req_valid & grant_s);
        case (grant_s)
            2'b10:   sel_id_s = REQ_MEM;
            default: sel_id_s = REQ_EX;
        endcase
        if (sel_id_s == REQ_MEM) begin
            sel_addr_s = req_addr1;
            sel_data_s = req_data1;
        end else begin
            sel_addr_s = req_addr0;
            sel_data_s = req_data0;
        end
        sel_legal_s = addr_ok(sel_addr_s);
        rsv_legal_s = addr_ok(rsv_addr);
        // Illegal writes are handshaken but never reach the register file.
        wr_accept_s = handshake_s & sel_legal_s;
    end

    // Scoreboard next state: clear on write, then set on reserve so set wins.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_accept_s && (sel_addr_s == ADDR_W'(i))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_next_s[i];
            end
            if (rsv_valid && rsv_legal_s && (rsv_addr == ADDR_W'(i))) begin
                pending_next_s[i] = 1'b1;
            end else begin
                pending_next_s[i] = pending_next_s[i];
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Write-port register: address/data hold when no write is issued.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
        end else if (wr_accept_s) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= sel_addr_s;
            write_data_r <= sel_data_s;
        end else begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= write_reg_r;
            write_data_r <= write_data_r;
        end
    end

    // Address error pulse for an out-of-range write or reservation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_err_r <= 1'b0;
        end else begin
            addr_err_r <= (handshake_s & ~sel_legal_s) | (rsv_valid & ~rsv_legal_s);
        end
    end

    // Operand stall: outstanding reservation or the write currently in flight.
    always_comb begin
        rd_stall_s = pend_lookup(pending_r, rd_addr1)
                   | pend_lookup(pending_r, rd_addr2)
                   | (reg_write_r & ((write_reg_r == rd_addr1) | (write_reg_r == rd_addr2)));
    end

    assign rd_stall   = rd_stall_s;
    assign RegWrite   = reg_write_r;
    assign Write_Reg  = write_reg_r;
    assign Write_Data = write_data_r;
    assign pending    = pending_r;
    assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler
// Directed, table-driven bench for regfile_wb_scheduler. Each table row is
// one clock cycle: inputs, the combinational results expected before the
// edge, and the registered results expected after it.
module tb_regfile_wb_scheduler;

    logic        Clk;
    logic        Reset;
    logic        wb_hold;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req_addr0, req_addr1;
    logic [31:0] req_data0, req_data1;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        rd_stall;
    logic        RegWrite;
    logic [4:0]  Write_Reg;
    logic [31:0] Write_Data;
    logic [15:0] pending;
    logic        addr_err;

    int pass_cnt;
    int total_cnt;

    regfile_wb_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .wb_hold    (wb_hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_stall   (rd_stall),
        .RegWrite   (RegWrite),
        .Write_Reg  (Write_Reg),
        .Write_Data (Write_Data),
        .pending    (pending),
        .addr_err   (addr_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        hold;
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        rsv;
        logic [4:0]  rsva;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic [1:0]  ready;
        logic        stall;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [15:0] pend;
        logic        err;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic [1:0] v,
                          input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1,
                          input logic rs, input logic [4:0] rsa,
                          input logic [4:0] r1, input logic [4:0] r2);
        wb_hold   = h;
        req_valid = v;
        req_addr0 = a0;
        req_data0 = d0;
        req_addr1 = a1;
        req_data1 = d1;
        rsv_valid = rs;
        rsv_addr  = rsa;
        rd_addr1  = r1;
        rd_addr2  = r2;
    endtask

    task automatic chk_regs(input string tag, input logic rw, input logic [4:0] wr,
                            input logic [31:0] wd, input logic [15:0] pend, input logic err);
        chk({tag, ".RegWrite"},   RegWrite,   rw);
        chk({tag, ".Write_Reg"},  Write_Reg,  wr);
        chk({tag, ".Write_Data"}, Write_Data, wd);
        chk({tag, ".pending"},    pending,    pend);
        chk({tag, ".addr_err"},   addr_err,   err);
    endtask

    initial begin
        string tag;
        pass_cnt  = 0;
        total_cnt = 0;

        // hold valid a0 d0 a1 d1 rsv rsva rd1 rd2 | ready stall | rw wr wd pend err
        vecs[0]  = '{1'b0, 2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b00, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b00, 1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 2'b11, 5'd1, 32'h11111111, 5'd2, 32'h22222222, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b1, 5'd1, 32'h11111111, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 5'd1, 32'h11111111, 5'd2, 32'h22222222, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b1, 5'd2, 32'h22222222, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 5'd1, 32'h11111111, 5'd2, 32'h22222222, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b1, 5'd1, 32'h11111111, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 2'b11, 5'd1, 32'h11111111, 5'd2, 32'h22222222, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b1, 5'd2, 32'h22222222, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0, 2'b00, 1'b0, 1'b0, 5'd2, 32'h22222222, 16'h0020, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 5'd2, 32'h22222222, 16'h0020, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 5'd2, 32'h22222222, 16'h0020, 1'b0};
        vecs[10] = '{1'b0, 2'b10, 5'd0, 32'h0, 5'd5, 32'h55555555, 1'b0, 5'd0, 5'd5, 5'd0, 2'b10, 1'b1, 1'b1, 5'd5, 32'h55555555, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 5'd5, 32'h55555555, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 1'b0, 1'b0, 5'd5, 32'h55555555, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 2'b01, 5'd7, 32'h77777777, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7, 2'b01, 1'b0, 1'b1, 5'd7, 32'h77777777, 16'h0080, 1'b0};
        vecs[14] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 2'b00, 1'b1, 1'b0, 5'd7, 32'h77777777, 16'h0080, 1'b0};
        vecs[15] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 2'b00, 1'b1, 1'b0, 5'd7, 32'h77777777, 16'h0080, 1'b0};
        vecs[16] = '{1'b0, 2'b01, 5'd20, 32'hAAAAAAAA, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 5'd7, 32'h77777777, 16'h0080, 1'b1};
        vecs[17] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd7, 32'h77777777, 16'h0080, 1'b0};
        vecs[18] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd7, 32'h77777777, 16'h0080, 1'b1};
        vecs[19] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd7, 32'h77777777, 16'h0080, 1'b0};
        vecs[20] = '{1'b0, 2'b01, 5'd0, 32'h0BADF00D, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd31, 2'b01, 1'b0, 1'b1, 5'd0, 32'h0BADF00D, 16'h0080, 1'b0};
        vecs[21] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd20, 2'b00, 1'b1, 1'b0, 5'd0, 32'h0BADF00D, 16'h0080, 1'b0};
        vecs[22] = '{1'b0, 2'b11, 5'd4, 32'h44444444, 5'd7, 32'h77770000, 1'b0, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 1'b1, 5'd4, 32'h44444444, 16'h0080, 1'b0};
        vecs[23] = '{1'b0, 2'b10, 5'd4, 32'h44444444, 5'd7, 32'h77770000, 1'b0, 5'd0, 5'd0, 5'd7, 2'b10, 1'b1, 1'b1, 5'd7, 32'h77770000, 16'h0000, 1'b0};
        vecs[24] = '{1'b0, 2'b11, 5'd4, 32'h44444444, 5'd6, 32'h66666666, 1'b0, 5'd0, 5'd0, 5'd7, 2'b10, 1'b1, 1'b1, 5'd6, 32'h66666666, 16'h0000, 1'b0};
        vecs[25] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 2'b00, 1'b0, 1'b0, 5'd6, 32'h66666666, 16'h0000, 1'b0};

        // Power-on reset with both producers requesting.
        Reset = 1'b1;
        set_in(1'b0, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 5'd0, 5'd0, 5'd0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("reset.req_ready", req_ready, 2'b00);
        chk("reset.rd_stall", rd_stall, 1'b0);
        chk_regs("reset", 1'b0, 5'd0, 32'h0, 16'h0000, 1'b0);
        Reset = 1'b0;

        // Table-driven main sequence.
        for (int i = 0; i < NV; i++) begin
            tag = $sformatf("vec%0d", i);
            set_in(vecs[i].hold, vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1,
                   vecs[i].d1, vecs[i].rsv, vecs[i].rsva, vecs[i].rd1, vecs[i].rd2);
            #2;
            chk({tag, ".req_ready"}, req_ready, vecs[i].ready);
            chk({tag, ".rd_stall"},  rd_stall,  vecs[i].stall);
            @(posedge Clk); #1;
            chk_regs(tag, vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].pend, vecs[i].err);
        end

        // wb_hold: reserve R11, issue a write, then freeze with both requesting.
        set_in(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd0, 5'd0);
        @(posedge Clk); #1;
        chk_regs("hold.rsv", 1'b0, 5'd6, 32'h66666666, 16'h0800, 1'b0);
        set_in(1'b0, 2'b01, 5'd9, 32'h99999999, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #2;
        chk("hold.pre.req_ready", req_ready, 2'b01);
        @(posedge Clk); #1;
        chk_regs("hold.pre", 1'b1, 5'd9, 32'h99999999, 16'h0800, 1'b0);
        set_in(1'b1, 2'b11, 5'd12, 32'hCCCCCCCC, 5'd13, 32'hDDDDDDDD, 1'b0, 5'd0, 5'd0, 5'd0);
        #2;
        chk("hold.rise.req_ready", req_ready, 2'b00);
        chk("hold.rise.inflight", RegWrite, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tag = $sformatf("hold%0d", k);
            @(posedge Clk); #1;
            chk_regs(tag, 1'b0, 5'd9, 32'h99999999, 16'h0800, 1'b0);
            chk({tag, ".req_ready"}, req_ready, 2'b00);
        end
        wb_hold = 1'b0;
        #2;
        chk("hold.fall.req_ready", req_ready, 2'b01);
        @(posedge Clk); #1;
        chk_regs("hold.fall", 1'b1, 5'd12, 32'hCCCCCCCC, 16'h0800, 1'b0);

        // Reset in the cycle after that handshake drops the write and the scoreboard.
        Reset = 1'b1;
        #2;
        chk("midrst.req_ready", req_ready, 2'b00);
        @(posedge Clk); #1;
        chk_regs("midrst", 1'b0, 5'd0, 32'h0, 16'h0000, 1'b0);
        Reset = 1'b0;
        #2;
        chk("midrst.ptr0.req_ready", req_ready, 2'b01);
        @(posedge Clk); #1;
        chk_regs("midrst.after", 1'b1, 5'd12, 32'hCCCCCCCC, 16'h0000, 1'b0);
        set_in(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(posedge Clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 16-entry, 32-bit register file of the multi-cycle core. Two producers compete for the single register-file write port: requester 0 is EX/ALU write-back and requester 1 is MEM/load write-back. The block arbitrates them round-robin, drives the write port from registers, and keeps a per-register pending scoreboard. Decode uses the scoreboard to stall operand reads until the producing write has landed.

## Interface

Parameters:
- NUM_REGS, 16, number of architectural registers; R14 = SP, R15 = RA.
- ADDR_W, 5, register address width (only addresses 0..NUM_REGS-1 are legal).
- DATA_W, 32, write data width.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- wb_hold  input  1  freeze: no grants, no write-port activity.
- req_valid  input  2  per-requester write request.
- req_ready  output  2  per-requester grant; handshake when valid&ready.
- req_addr0 / req_addr1  input  ADDR_W  destination register.
- req_data0 / req_data1  input  DATA_W  write data.
- rsv_valid  input  1  decode reserves a destination register.
- rsv_addr  input  ADDR_W  register being reserved.
- rd_addr1 / rd_addr2  input  ADDR_W  operand addresses decode is about to read.
- rd_stall  output  1  operand not yet valid in the register file.
- RegWrite  output  1  register-file write enable (registered).
- Write_Reg  output  ADDR_W  register-file write address (registered).
- Write_Data  output  DATA_W  register-file write data (registered).
- pending  output  NUM_REGS  scoreboard bit per register.
- addr_err  output  1  one-cycle pulse on an illegal address.

## Operation

- **Arbitration (combinational):**
  - With wb_hold=0 and exactly one req_valid set, that requester is granted.
  - With both valid, the requester selected by rr_ptr is granted.
  - With wb_hold=1, req_ready = 2'b00.
  - At most one req_ready bit is ever high.
- **rr_ptr update:**
  - Reset value 0.
  - After a contested grant (both valid), rr_ptr points to the loser.
  - Uncontested grants leave rr_ptr unchanged.
- **Write-port register:**
  - On a granted handshake, the next edge loads RegWrite=1, Write_Reg=req_addr, Write_Data=req_data.
  - Otherwise the next edge loads RegWrite=0; Write_Reg and Write_Data hold their values.
- **Illegal address (addr >= NUM_REGS):**
  - A granted request with an illegal address is still accepted (ready=1), so the producer is not blocked.
  - RegWrite stays 0 for that write.
  - addr_err pulses the next cycle.
  - An illegal rsv_addr likewise pulses addr_err and sets no pending bit.
- **Scoreboard:**
  - rsv_valid sets pending[rsv_addr] at the edge.
  - A granted write to addr clears pending[addr] at the same edge it loads the write-port register.
  - If a set and a clear hit the same address in the same cycle, the set wins (a newer reservation is outstanding).
  - Writing an address that has no pending bit is legal and only updates the register file.
- **rd_stall (combinational):**
  - rd_stall = pending[rd_addr1] | pending[rd_addr2] | (RegWrite & (Write_Reg == rd_addr1 | Write_Reg == rd_addr2)).
  - The RegWrite term covers the write in flight to the register file.
  - Illegal rd addresses never stall.

## Timing

- **Reset values:** req_ready=0, RegWrite=0, Write_Reg=0, Write_Data=0, pending=0, addr_err=0, rr_ptr=0.
- **Reset mid-operation:**
  - An in-flight registered write is dropped: RegWrite is 0 in the cycle after Reset.
  - All reservations are lost.
- **Latency:**
  - Handshake in cycle N → RegWrite high in cycle N+1.
  - The register file captures the data at the end of cycle N+1.
  - A read issued in cycle N+2 sees the new value.
- **Stall window:** rd_stall for a reserved register stays high from the cycle after rsv_valid until cycle N+1 inclusive.
- **Throughput:** one write per cycle. Back-to-back writes from alternating requesters produce a continuous RegWrite.
- **wb_hold:**
  - When wb_hold rises, the already registered write still completes in the next cycle.
  - From the following cycle RegWrite=0 until wb_hold falls.
  - The scoreboard keeps its state during the hold.

## Structure

- **Package regfile_pkg:**
  - NUM_REGS, ADDR_W, DATA_W constants.
  - REG_SP=14, REG_RA=15 constants.
  - SP_RESET=32'h1000 constant.
  - Requester-ID enum: REQ_EX=0, REQ_MEM=1.
- **Sub-module rr_arbiter2:** two-input round-robin arbiter with hold. Contains the rr_ptr flop and a one-hot grant output.
- **Top level contains:** the scoreboard register, the write-port output register, the address check, and the stall compare.

## Test plan

- Reset, then EX writes R3=32'hDEADBEEF: req_ready0=1 in cycle 0; cycle 1 shows RegWrite=1, Write_Reg=3, Write_Data=DEADBEEF; a read of R3 in cycle 2 returns DEADBEEF.
- Both requesters valid for 4 cycles (EX→R1, MEM→R2): grants alternate 0,1,0,1; RegWrite is continuous; rr_ptr toggles each cycle.
- rsv R5, then MEM writes R5 three cycles later: rd_stall=1 (rd_addr1=5) from the cycle after rsv through the RegWrite cycle; 0 afterwards; pending[5] cleared.
- rsv R7 and a granted write to R7 in the same cycle: pending[7]=1 afterwards; rd_stall stays high for rd_addr2=7.
- EX writes to address 20: req_ready0=1, RegWrite stays 0, addr_err pulses for one cycle, no pending bit changes.
- Reset asserted in the cycle after a handshake, and wb_hold=1 with both valid: RegWrite=0 after Reset, pending=0; under wb_hold, req_ready=00 for the whole hold.
